// File: rtl/dds_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared types and constants for the DDS front-panel tuner.
//   state_t     : controller FSM states
//   STEP_SHIFT  : bit distance between successive step sizes
//   NUM_STEPS   : number of selectable step sizes
//   step_sel_t  : step index type
//   step_shamt  : shift amount that turns a step index into a step size
// ----------------------------------------------------------------------------
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CALC,
        S_SEND
    } state_t;

    localparam int STEP_SHIFT = 8;
    localparam int NUM_STEPS  = 4;

    typedef logic [1:0] step_sel_t;

    // Step size is 1 << (STEP_SHIFT * sel): 1, 2^8, 2^16, 2^24.
    function automatic int unsigned step_shamt(input step_sel_t sel);
        return 32'(STEP_SHIFT) * 32'(sel);
    endfunction

endpackage

// File: rtl/button_repeat.sv
// ----------------------------------------------------------------------------
// button_repeat
// Turns a debounced button level into single-cycle events: one on press and,
// when REPEAT_EN is set, further events while the button stays held (first
// after HOLD_CYCLES, then every REPEAT_CYCLES until release).
// Ports:
//   clk_in     : clock, rising edge
//   rst_n_in   : synchronous active-low reset
//   btn_in     : debounced button level, 1 = pressed
//   event_out  : registered 1-cycle event pulse
// ----------------------------------------------------------------------------
module button_repeat #(
    parameter int HOLD_CYCLES   = 5_000_000,
    parameter int REPEAT_CYCLES = 1_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic btn_in,
    output logic event_out
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);

    logic             btn_q;
    logic             btn_prev;
    logic             repeating;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] limit;

    // Once the first auto-repeat has fired, the counter measures the shorter
    // repeat interval instead of the initial hold time.
    assign limit = repeating ? REP_C : HOLD_C;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            btn_q     <= 1'b0;
            btn_prev  <= 1'b0;
            repeating <= 1'b0;
            hold_cnt  <= '0;
            event_out <= 1'b0;
        end else begin
            btn_q     <= btn_in;
            btn_prev  <= btn_q;
            event_out <= btn_q && !btn_prev;

            // hold_cnt holds the number of held cycles seen so far; reaching
            // the limit fires an event and restarts counting at 1 so the
            // next event lands exactly REPEAT_CYCLES later.
            if (REPEAT_EN && btn_q) begin
                if (hold_cnt == limit) begin
                    event_out <= 1'b1;
                    hold_cnt  <= CNT_W'(1);
                    repeating <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                end
            end else begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dds_button_tuner.sv
// ----------------------------------------------------------------------------
// dds_button_tuner
// Front-panel controller: up/down buttons add/subtract the selected step to
// the DDS frequency tuning word with saturation, the step button cycles the
// step size, and every new word is offered to the DDS over valid/ready.
// Ports:
//   clk_in        : system clock, rising edge
//   rst_n_in      : synchronous active-low reset
//   btn_up_in     : debounced up button level
//   btn_down_in   : debounced down button level
//   btn_step_in   : debounced step-select button level
//   ftw_out       : current tuning word
//   ftw_valid_out : ftw_out offered to the DDS
//   ftw_ready_in  : DDS accepts ftw_out
//   step_sel_out  : current step index 0..3
//   busy_out      : high whenever the FSM is not idle
//
// Handshake: a word transfers on a rising edge where ftw_valid_out and
// ftw_ready_in are both 1. Once raised, ftw_valid_out stays high and ftw_out
// stays constant until that transfer; valid drops on the following edge.
// ----------------------------------------------------------------------------
module dds_button_tuner
    import dds_ctrl_pkg::*;
#(
    parameter int               FTW_W         = 32,
    parameter int               HOLD_CYCLES   = 5_000_000,
    parameter int               REPEAT_CYCLES = 1_000_000,
    parameter logic [FTW_W-1:0] FTW_RESET     = 32'h0100_0000,
    parameter logic [FTW_W-1:0] FTW_MAX       = 32'hFFFF_FFFF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             btn_up_in,
    input  logic             btn_down_in,
    input  logic             btn_step_in,
    output logic [FTW_W-1:0] ftw_out,
    output logic             ftw_valid_out,
    input  logic             ftw_ready_in,
    output step_sel_t        step_sel_out,
    output logic             busy_out
);

    localparam int EXT_W = FTW_W + 1;
    typedef logic [EXT_W-1:0] ext_t;

    logic up_ev;
    logic down_ev;
    logic step_ev;

    button_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b1)
    ) u_up (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .btn_in   (btn_up_in),
        .event_out(up_ev)
    );

    button_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b1)
    ) u_down (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .btn_in   (btn_down_in),
        .event_out(down_ev)
    );

    button_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .REPEAT_EN    (1'b0)
    ) u_step (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .btn_in   (btn_step_in),
        .event_out(step_ev)
    );

    // FSM state; busy_out is its externally visible summary.
    state_t state;
    logic   up_pend;
    logic   down_pend;

    ext_t             step_ext;
    ext_t             cur_ext;
    ext_t             sum_ext;
    logic [FTW_W-1:0] up_res;
    logic [FTW_W-1:0] down_res;
    logic [FTW_W-1:0] calc_res;

    // Saturating arithmetic in FTW_W+1 bits so the add can never wrap.
    always_comb begin
        step_ext = ext_t'(1) << step_shamt(step_sel_out);
        cur_ext  = {1'b0, ftw_out};
        sum_ext  = cur_ext + step_ext;
        up_res   = (sum_ext > {1'b0, FTW_MAX}) ? FTW_MAX : sum_ext[FTW_W-1:0];
        down_res = (cur_ext < step_ext) ? '0 : (ftw_out - step_ext[FTW_W-1:0]);
        calc_res = ftw_out;
        if (up_pend && !down_pend) begin
            calc_res = up_res;
        end else if (down_pend && !up_pend) begin
            calc_res = down_res;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= S_INIT;
            ftw_out       <= FTW_RESET;
            ftw_valid_out <= 1'b0;
            step_sel_out  <= '0;
            up_pend       <= 1'b0;
            down_pend     <= 1'b0;
            busy_out      <= 1'b1;
        end else begin
            if (step_ev) begin
                step_sel_out <= (step_sel_out == step_sel_t'(NUM_STEPS - 1)) ?
                                '0 : step_sel_out + step_sel_t'(1);
            end

            // Events accumulate while the FSM is busy; repeats coalesce.
            up_pend   <= up_pend | up_ev;
            down_pend <= down_pend | down_ev;

            case (state)
                S_INIT: begin
                    ftw_valid_out <= 1'b1;
                    busy_out      <= 1'b1;
                    state         <= S_SEND;
                end
                S_IDLE: begin
                    // Looking at the raw event too lets a press reach S_CALC
                    // one cycle after its event pulse.
                    if (up_pend || down_pend || up_ev || down_ev) begin
                        busy_out <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Pending flags are consumed here; only events arriving
                    // in this very cycle survive into the next round.
                    up_pend   <= up_ev;
                    down_pend <= down_ev;
                    if (calc_res != ftw_out) begin
                        ftw_out       <= calc_res;
                        ftw_valid_out <= 1'b1;
                        state         <= S_SEND;
                    end else begin
                        // Opposite requests cancelled or already saturated.
                        busy_out <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (ftw_ready_in) begin
                        ftw_valid_out <= 1'b0;
                        busy_out      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_button_tuner.sv
// ----------------------------------------------------------------------------
// tb_dds_button_tuner
// Self-checking bench for dds_button_tuner with short hold/repeat times.
// A behavioural model tracks button hold lengths and the controller's
// idle/calc/send progress; every cycle the DUT outputs are compared with the
// model, and every accepted word is matched against an expected queue.
// ----------------------------------------------------------------------------
module tb_dds_button_tuner;

    localparam int          HOLD      = 10;
    localparam int          REP       = 4;
    localparam logic [31:0] RST_WORD  = 32'h0000_1000;
    localparam longint unsigned MAX_M = 64'h0000_0000_FFFF_FFFF;

    localparam int PH_INIT = 0;
    localparam int PH_IDLE = 1;
    localparam int PH_CALC = 2;
    localparam int PH_SEND = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        btn_up_in;
    logic        btn_down_in;
    logic        btn_step_in;
    logic [31:0] ftw_out;
    logic        ftw_valid_out;
    logic        ftw_ready_in;
    logic [1:0]  step_sel_out;
    logic        busy_out;

    always #5 clk_in = ~clk_in;

    dds_button_tuner #(
        .FTW_W        (32),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .FTW_RESET    (RST_WORD),
        .FTW_MAX      (32'hFFFF_FFFF)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .btn_up_in    (btn_up_in),
        .btn_down_in  (btn_down_in),
        .btn_step_in  (btn_step_in),
        .ftw_out      (ftw_out),
        .ftw_valid_out(ftw_valid_out),
        .ftw_ready_in (ftw_ready_in),
        .step_sel_out (step_sel_out),
        .busy_out     (busy_out)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int writes = 0;

    // ---------------- reference model state ----------------
    int              r_up, r_dn, r_st;   // consecutive sampled-high cycles
    bit              e_up, e_dn, e_st;   // event visible during this cycle
    bit              p_up, p_dn;
    longint unsigned m_ftw;
    bit              m_valid;
    int              m_step;
    int              m_phase;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event rule: one on the first held cycle, then after HOLD held cycles,
    // then every REP cycles (repeat-capable buttons only).
    function automatic bit fires(input int r, input bit rep);
        if (r == 1) return 1'b1;
        if (rep && r >= HOLD + 1 && ((r - HOLD - 1) % REP) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        r_up = 0; r_dn = 0; r_st = 0;
        e_up = 0; e_dn = 0; e_st = 0;
        p_up = 0; p_dn = 0;
        m_ftw = 64'(RST_WORD);
        m_valid = 0;
        m_step = 0;
        m_phase = PH_INIT;
    endtask

    task automatic model_step();
        bit a_up, a_dn;
        longint unsigned stp, res;
        if (!rst_n_in) begin
            model_reset();
            return;
        end
        a_up = p_up | e_up;
        a_dn = p_dn | e_dn;
        case (m_phase)
            PH_INIT: begin
                m_valid = 1; m_phase = PH_SEND; p_up = a_up; p_dn = a_dn;
            end
            PH_IDLE: begin
                p_up = a_up; p_dn = a_dn;
                if (a_up || a_dn) m_phase = PH_CALC;
            end
            PH_CALC: begin
                stp = 64'd1 << (8 * m_step);
                res = m_ftw;
                if (p_up && !p_dn) res = (m_ftw + stp > MAX_M) ? MAX_M : m_ftw + stp;
                else if (p_dn && !p_up) res = (m_ftw < stp) ? 64'd0 : m_ftw - stp;
                p_up = e_up; p_dn = e_dn;
                if (res != m_ftw) begin
                    m_ftw = res; m_valid = 1; m_phase = PH_SEND;
                end else begin
                    m_phase = PH_IDLE;
                end
            end
            default: begin
                p_up = a_up; p_dn = a_dn;
                if (ftw_ready_in) begin
                    exp_q.push_back(32'(m_ftw));
                    m_valid = 0;
                    m_phase = PH_IDLE;
                end
            end
        endcase
        if (e_st) m_step = (m_step + 1) % 4;
        e_up = fires(r_up, 1'b1);
        e_dn = fires(r_dn, 1'b1);
        e_st = fires(r_st, 1'b0);
        r_up = btn_up_in   ? r_up + 1 : 0;
        r_dn = btn_down_in ? r_dn + 1 : 0;
        r_st = btn_step_in ? r_st + 1 : 0;
    endtask

    // One clock: note a handshake before the edge, advance the model at the
    // edge, compare everything 1 time unit later.
    task automatic cycle();
        logic        hs;
        logic [31:0] hs_word;
        hs      = ftw_valid_out && ftw_ready_in && rst_n_in;
        hs_word = ftw_out;
        @(posedge clk_in);
        model_step();
        #1;
        cyc++;
        if (!rst_n_in) writes = 0;
        if (hs) begin
            writes++;
            check_val("hs_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_val("hs_word", hs_word, exp_q.pop_front());
        end
        check_val("hs_missing", 32'(exp_q.size()), 32'd0);
        check_val("valid", 32'(ftw_valid_out), 32'(m_valid));
        check_val("ftw", ftw_out, 32'(m_ftw));
        check_val("step_sel", 32'(step_sel_out), 32'(m_step));
        check_val("busy", 32'(busy_out), 32'(m_phase != PH_IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_up_in = v;
            1: btn_down_in = v;
            2: btn_step_in = v;
            default: begin btn_up_in = v; btn_down_in = v; end
        endcase
    endtask

    task automatic press(input int which, input int len);
        set_btn(which, 1'b1);
        repeat (len) cycle();
        set_btn(which, 1'b0);
        repeat (2) cycle();
    endtask

    task automatic settle(input string tag);
        repeat (12) cycle();
        check_val(tag, 32'(busy_out), 32'd0);
    endtask

    task automatic do_reset();
        rst_n_in = 0;
        ftw_ready_in = 1;
        btn_up_in = 0; btn_down_in = 0; btn_step_in = 0;
        repeat (3) cycle();
        rst_n_in = 1;
        settle("reset_idle");
        check_val("reset_ftw", ftw_out, RST_WORD);
        check_val("reset_writes", 32'(writes), 32'd1);
    endtask

    // 3-cycle tap; returns how many clocks until valid appeared.
    task automatic tap_measure(input int which, output int lat);
        lat = 0;
        set_btn(which, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (i == 3) set_btn(which, 1'b0);
            if (ftw_valid_out && lat == 0) lat = i;
            if (lat != 0 && i >= 3) break;
        end
        set_btn(which, 1'b0);
        if (lat == 0) check_val("tap_valid_timeout", 32'(ftw_valid_out), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        model_reset();
        rst_n_in = 0; ftw_ready_in = 1;
        btn_up_in = 0; btn_down_in = 0; btn_step_in = 0;

        // Reset, then a single up tap at step 0.
        do_reset();
        tap_measure(0, lat);
        check_val("up_latency", 32'(lat), 32'd4);
        settle("up_idle");
        check_val("up_ftw", ftw_out, 32'h0000_1001);
        check_val("up_writes", 32'(writes), 32'd2);

        // Hold down 30 cycles at step 1: press plus five auto-repeats.
        do_reset();
        press(2, 2);
        check_val("step1_sel", 32'(step_sel_out), 32'd1);
        press(1, 30);
        settle("hold_idle");
        check_val("hold_ftw", ftw_out, 32'h0000_0A00);
        check_val("hold_writes", 32'(writes), 32'd7);

        // Step 3, hold up until saturated at the top, then extra taps.
        do_reset();
        press(2, 2); press(2, 2); press(2, 2);
        check_val("step3_sel", 32'(step_sel_out), 32'd3);
        press(0, 1100);
        settle("sat_idle");
        check_val("sat_hi_ftw", ftw_out, 32'hFFFF_FFFF);
        check_val("sat_hi_writes", 32'(writes), 32'd257);
        press(0, 3);
        settle("sat_tap_idle");
        check_val("sat_hi_nowrite", 32'(writes), 32'd257);
        press(2, 2);
        check_val("step_wrap", 32'(step_sel_out), 32'd0);
        press(1, 3);
        settle("sat_down_idle");
        check_val("sat_down_ftw", ftw_out, 32'hFFFF_FFFE);

        // Step 1, hold down past zero.
        do_reset();
        press(2, 2);
        press(1, 120);
        settle("zero_idle");
        check_val("sat_lo_ftw", ftw_out, 32'h0000_0000);
        check_val("sat_lo_writes", 32'(writes), 32'd17);

        // Ready held low while two more up taps arrive: word stays put.
        do_reset();
        ftw_ready_in = 0;
        tap_measure(0, lat);
        check_val("stall_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 20; i++) begin
            btn_up_in = ((i >= 2 && i <= 4) || (i >= 8 && i <= 10));
            cycle();
            check_val("stall_valid", 32'(ftw_valid_out), 32'd1);
            check_val("stall_ftw", ftw_out, 32'h0000_1001);
        end
        btn_up_in = 0;
        ftw_ready_in = 1;
        settle("stall_idle");
        check_val("stall_final_ftw", ftw_out, 32'h0000_1002);
        check_val("stall_writes", 32'(writes), 32'd3);

        // Up and down in the same cycle cancel.
        do_reset();
        press(3, 3);
        settle("cancel_idle");
        check_val("cancel_ftw", ftw_out, RST_WORD);
        check_val("cancel_writes", 32'(writes), 32'd1);

        // Reset in the middle of a stalled send.
        do_reset();
        ftw_ready_in = 0;
        tap_measure(0, lat);
        rst_n_in = 0;
        cycle();
        check_val("rst_mid_valid", 32'(ftw_valid_out), 32'd0);
        check_val("rst_mid_ftw", ftw_out, RST_WORD);
        rst_n_in = 1;
        ftw_ready_in = 1;
        cycle();
        check_val("resend_valid", 32'(ftw_valid_out), 32'd1);
        check_val("resend_ftw", ftw_out, RST_WORD);
        settle("resend_idle");
        check_val("resend_writes", 32'(writes), 32'd1);

        // Random buttons, ready and occasional reset.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) btn_up_in = ~btn_up_in;
            if ($urandom_range(0, 7) == 0) btn_down_in = ~btn_down_in;
            if ($urandom_range(0, 19) == 0) btn_step_in = ~btn_step_in;
            ftw_ready_in = ($urandom_range(0, 3) != 0);
            rst_n_in = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n_in = 1;
        btn_up_in = 0; btn_down_in = 0; btn_step_in = 0;
        ftw_ready_in = 1;
        settle("random_idle");
        check_val("random_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
